// File: rtl/quad_sample_scheduler.sv
// quad_sample_scheduler
//
// Periodic sampling controller for the quadrature encoder counters in the
// myo-muscle position path. A programmable down-counter produces a sample
// tick. On each tick all NUM_ENC raw counts are snapshotted in one cycle.
// A single shared subtractor then walks the channels one per cycle to form
// offset-corrected positions and per-period deltas. The results are
// published to the Avalon-MM register bank in one cycle, so software never
// sees a half-updated set.
//
// Parameters:
//   NUM_ENC         number of encoder channels (1..4)
//   DEFAULT_PERIOD  sample period in clk cycles after reset
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   address        Avalon word address
//   write          Avalon write strobe (zero wait states)
//   writedata      Avalon write data
//   read           Avalon read strobe
//   readdata       Avalon read data, registered, held until the next read
//   waitrequest    high for the first cycle of every read
//   counts         raw signed counts; channel i at bits [32i+31:32i]
//   sample_strobe  one-cycle pulse in the publish cycle
//   irq            interrupt, present only when QUAD_SCHED_IRQ_EN is defined
//
// Register map:
//   0 CTRL    bit0 enable, bit1 irq_en
//   1 PERIOD  values below 16 are clamped to 16; a write restarts the timer
//   2 SEQ     publish count (read-only)
//   3 STATUS  bit0 busy (ro), bit1 overrun (w1c), bit2 irq pending (w1c)
//   4+i POS_i   position (read); any write captures offset_i from counts
//   8+i DELTA_i delta since the previous sample (read-only)
//   other addresses read 32'hDEADBEEF
//
// Build option: define QUAD_SCHED_IRQ_EN to add the interrupt logic and the
// irq port. Without it CTRL bit1 and STATUS bit2 ignore writes and read 0.

module quad_sample_scheduler #(
    parameter int          NUM_ENC        = 2,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             address,
    input  logic                   write,
    input  logic [31:0]            writedata,
    input  logic                   read,
    output logic [31:0]            readdata,
    output logic                   waitrequest,
    input  logic [32*NUM_ENC-1:0]  counts,
    output logic                   sample_strobe
`ifdef QUAD_SCHED_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LATCH   = 2'd1;
    localparam logic [1:0] S_DIFF    = 2'd2;
    localparam logic [1:0] S_PUBLISH = 2'd3;

    localparam int               IDX_W      = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ENC - 1);
    localparam logic [31:0]      MIN_PERIOD = 32'd16;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;

    logic             enable;
    logic [31:0]      period;
    logic [31:0]      timer;
    logic             tick;
    logic [31:0]      seq;
    logic             overrun;
    logic             first_sample;
    logic             rd_pending;

    logic [31:0] raw          [NUM_ENC];
    logic [31:0] offset       [NUM_ENC];
    logic [31:0] snap_raw     [NUM_ENC];
    logic [31:0] snap_off     [NUM_ENC];
    logic [31:0] prev_raw     [NUM_ENC];
    logic [31:0] shadow_pos   [NUM_ENC];
    logic [31:0] shadow_delta [NUM_ENC];
    logic [31:0] pos          [NUM_ENC];
    logic [31:0] delta        [NUM_ENC];

    logic        irq_en_bit;
    logic        pending_bit;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        wr_en, wr_ctrl, wr_period, wr_status, enable_rise;
    logic [31:0] period_wr;
    logic        chan_ok;

    // Read is stalled exactly one cycle while readdata is being registered.
    assign waitrequest = read & ~rd_pending;
    assign wr_en       = write & ~waitrequest;
    assign wr_ctrl     = wr_en && (address == 4'd0);
    assign wr_period   = wr_en && (address == 4'd1);
    assign wr_status   = wr_en && (address == 4'd3);
    assign enable_rise = wr_ctrl && writedata[0] && !enable;
    assign period_wr   = (writedata < MIN_PERIOD) ? MIN_PERIOD : writedata;
    assign chan_ok     = int'(address[1:0]) < NUM_ENC;

    always_comb begin
        for (int i = 0; i < NUM_ENC; i++) begin
            raw[i] = counts[32*i +: 32];
        end
    end

    // ------------------------------------------------------------------
    // Sample timer
    // ------------------------------------------------------------------
    assign tick = enable && (timer == 32'd0);

    // NOTE: every clocked block uses non-blocking assignments so all flops
    // update from the same pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            period <= DEFAULT_PERIOD;
            timer  <= DEFAULT_PERIOD - 32'd1;
        end else begin
            if (wr_ctrl) begin
                enable <= writedata[0];
            end
            if (wr_period) begin
                period <= period_wr;
                timer  <= period_wr - 32'd1;
            end else if (!enable || timer == 32'd0) begin
                timer  <= period - 32'd1;
            end else begin
                timer  <= timer - 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared subtractor: one channel per DIFF cycle
    // ------------------------------------------------------------------
    logic [31:0] sel_raw, sel_off, sel_prev, sel_pos, sel_delta;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sel_raw  = snap_raw[0];
        sel_off  = snap_off[0];
        sel_prev = prev_raw[0];
        for (int i = 0; i < NUM_ENC; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_raw  = snap_raw[i];
                sel_off  = snap_off[i];
                sel_prev = prev_raw[i];
            end
        end
    end

    assign sel_pos   = sel_raw - sel_off;
    assign sel_delta = first_sample ? 32'd0 : (sel_raw - sel_prev);

    // ------------------------------------------------------------------
    // Sequencer and result registers
    // ------------------------------------------------------------------
    // NOTE: the per-channel arrays are small flop banks rather than RAM, so
    // they take the asynchronous reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            seq          <= 32'd0;
            overrun      <= 1'b0;
            first_sample <= 1'b1;
            for (int i = 0; i < NUM_ENC; i++) begin
                offset[i]       <= 32'd0;
                snap_raw[i]     <= 32'd0;
                snap_off[i]     <= 32'd0;
                prev_raw[i]     <= 32'd0;
                shadow_pos[i]   <= 32'd0;
                shadow_delta[i] <= 32'd0;
                pos[i]          <= 32'd0;
                delta[i]        <= 32'd0;
            end
        end else begin
            // Offset capture uses the live count, not the snapshot.
            for (int i = 0; i < NUM_ENC; i++) begin
                if (wr_en && address[3:2] == 2'b01 && address[1:0] == 2'(i)) begin
                    offset[i] <= raw[i];
                end
            end

            // A tick that finds the sequencer busy is dropped; set beats clear.
            if (tick && state != S_IDLE) begin
                overrun <= 1'b1;
            end else if (wr_status && writedata[1]) begin
                overrun <= 1'b0;
            end

            if (enable_rise) begin
                first_sample <= 1'b1;
            end else if (state == S_PUBLISH) begin
                first_sample <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // Offsets are frozen with the counts, so an offset write
                    // landing here only affects the following sample.
                    for (int i = 0; i < NUM_ENC; i++) begin
                        snap_raw[i] <= raw[i];
                        snap_off[i] <= offset[i];
                    end
                    idx   <= '0;
                    state <= S_DIFF;
                end
                S_DIFF: begin
                    for (int i = 0; i < NUM_ENC; i++) begin
                        if (idx == IDX_W'(i)) begin
                            shadow_pos[i]   <= sel_pos;
                            shadow_delta[i] <= sel_delta;
                            prev_raw[i]     <= sel_raw;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_PUBLISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    for (int i = 0; i < NUM_ENC; i++) begin
                        pos[i]   <= shadow_pos[i];
                        delta[i] <= shadow_delta[i];
                    end
                    seq   <= seq + 32'd1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign sample_strobe = (state == S_PUBLISH);

    // ------------------------------------------------------------------
    // Optional interrupt
    // ------------------------------------------------------------------
`ifdef QUAD_SCHED_IRQ_EN
    logic irq_en, irq_pending, irq_en_nxt, irq_pending_nxt;

    always_comb begin
        irq_en_nxt      = wr_ctrl ? writedata[1] : irq_en;
        irq_pending_nxt = irq_pending;
        if (wr_status && writedata[2]) begin
            irq_pending_nxt = 1'b0;
        end
        // A publish in the same cycle as a clear wins.
        if (state == S_PUBLISH) begin
            irq_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
            irq         <= 1'b0;
        end else begin
            irq_en      <= irq_en_nxt;
            irq_pending <= irq_pending_nxt;
            irq         <= irq_pending_nxt & irq_en_nxt;
        end
    end

    assign irq_en_bit  = irq_en;
    assign pending_bit = irq_pending;
`else
    assign irq_en_bit  = 1'b0;
    assign pending_bit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'hDEADBEEF;
        case (address)
            4'd0: rd_mux = {30'd0, irq_en_bit, enable};
            4'd1: rd_mux = period;
            4'd2: rd_mux = seq;
            4'd3: rd_mux = {29'd0, pending_bit, overrun, (state != S_IDLE)};
            default: begin
                if (chan_ok && (address[3:2] == 2'b01 || address[3:2] == 2'b10)) begin
                    for (int i = 0; i < NUM_ENC; i++) begin
                        if (address[1:0] == 2'(i)) begin
                            rd_mux = address[3] ? delta[i] : pos[i];
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata   <= 32'd0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= waitrequest;
            if (waitrequest) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_quad_sample_scheduler.sv
// Directed testbench for quad_sample_scheduler (NUM_ENC = 2, PERIOD = 16 in
// use). Expected values are hand-computed constants. Works with and without
// QUAD_SCHED_IRQ_EN; interrupt checks are only compiled in when it is set.

module tb_quad_sample_scheduler;

`ifdef QUAD_SCHED_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [63:0] counts;
    logic        sample_strobe;
    logic [31:0] c0, c1;
`ifdef QUAD_SCHED_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    assign counts = {c1, c0};

    always #5 clk = ~clk;

    quad_sample_scheduler #(
        .NUM_ENC        (2),
        .DEFAULT_PERIOD (32'd50000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .read          (read),
        .readdata      (readdata),
        .waitrequest   (waitrequest),
        .counts        (counts),
        .sample_strobe (sample_strobe)
`ifdef QUAD_SCHED_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        int w;
        @(negedge clk);
        address = a;
        read    = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (waitrequest && w < 8);
        if (waitrequest) check("read_timeout", 32'(waitrequest), 32'd0);
        d    = readdata;
        read = 1'b0;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (sample_strobe !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", 32'(sample_strobe), 32'd1);
    endtask

    task automatic read_sample(input string pre, input logic [31:0] seq_e,
                               input logic [31:0] p0, input logic [31:0] p1,
                               input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] d;
        bus_read(4'd2, d); check({pre, "_seq"},    d, seq_e);
        bus_read(4'd4, d); check({pre, "_pos0"},   d, p0);
        bus_read(4'd5, d); check({pre, "_pos1"},   d, p1);
        bus_read(4'd8, d); check({pre, "_delta0"}, d, d0);
        bus_read(4'd9, d); check({pre, "_delta1"}, d, d1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          n;

        reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        c0 = 32'd100; c1 = 32'(-5);
        repeat (3) @(negedge clk);
        check("rst_readdata",    readdata, 32'd0);
        check("rst_waitrequest", 32'(waitrequest), 32'd0);
        check("rst_strobe",      32'(sample_strobe), 32'd0);
        reset = 1'b0;

        // Read handshake: stall in the assertion cycle, data the cycle after.
        @(negedge clk);
        address = 4'd2; read = 1'b1;
        #1 check("wait_assert", 32'(waitrequest), 32'd1);
        @(negedge clk);
        check("wait_release", 32'(waitrequest), 32'd0);
        check("seq_reset", readdata, 32'd0);
        read = 1'b0;

        bus_read(4'd0,  d); check("ctrl_reset",   d, 32'd0);
        bus_read(4'd1,  d); check("period_reset", d, 32'd50000);
        bus_read(4'd3,  d); check("status_reset", d, 32'd0);
        bus_read(4'd4,  d); check("pos0_reset",   d, 32'd0);
        bus_read(4'd9,  d); check("delta1_reset", d, 32'd0);
        bus_read(4'd12, d); check("unmapped",     d, 32'hDEADBEEF);

        bus_write(4'd1, 32'd16);
        bus_read(4'd1, d); check("period_16", d, 32'd16);

        // First sample after enable: strobe 20 cycles after the write.
        bus_write(4'd0, 32'd1);
        wait_strobe(n);
        check("strobe_latency", 32'(n + 1), 32'd20);
        c0 = 32'd103; c1 = 32'(-12);
        @(negedge clk);
        check("strobe_width", 32'(sample_strobe), 32'd0);
        read_sample("s1", 32'd1, 32'd100, 32'(-5), 32'd0, 32'd0);

        wait_strobe(n);
        c0 = 32'd106; c1 = 32'(-19);
        read_sample("s2", 32'd2, 32'd103, 32'(-12), 32'd3, 32'(-7));

        wait_strobe(n);
        c0 = 32'h7FFFFFFF; c1 = 32'(-26);
        read_sample("s3", 32'd3, 32'd106, 32'(-19), 32'd3, 32'(-7));

        wait_strobe(n);
        c0 = 32'h80000002; c1 = 32'(-33);
        read_sample("s4", 32'd4, 32'h7FFFFFFF, 32'(-26), 32'h7FFFFF95, 32'(-7));

        wait_strobe(n);
        c0 = 32'd500; c1 = 32'(-40);
        read_sample("s5", 32'd5, 32'h80000002, 32'(-33), 32'd3, 32'(-7));

        // Capture offset_0 = 500, then move the count to 510.
        wait_strobe(n);
        c1 = 32'(-47);
        read_sample("s6", 32'd6, 32'd500, 32'(-40), 32'h800001F2, 32'(-7));
        bus_write(4'd4, 32'd0);
        c0 = 32'd510;

        wait_strobe(n);
        read_sample("s7", 32'd7, 32'd10, 32'(-47), 32'd10, 32'(-7));

        bus_write(4'd1, 32'd3);
        bus_read(4'd1, d); check("period_clamp", d, 32'd16);
        @(negedge clk);
        check("rd_hold", readdata, 32'd16);

        // Overrun: inject a tick in the first DIFF cycle of the next sample.
        wait_strobe(n);
        repeat (14) @(negedge clk);
        force dut.tick = 1'b1;
        @(negedge clk);
        release dut.tick;
        wait_strobe(n);
        bus_write(4'd0, 32'd0);
        bus_read(4'd2, d); check("seq_after_overrun", d, 32'd9);
        bus_read(4'd3, d);
        check("overrun_set", 32'(d[1]), 32'd1);
        check("status_overrun", d, IRQ ? 32'd6 : 32'd2);
        bus_write(4'd3, 32'd2);
        bus_read(4'd3, d); check("overrun_clear", d, IRQ ? 32'd4 : 32'd0);
        bus_write(4'd3, 32'd4);
        bus_read(4'd3, d); check("pending_clear", d, 32'd0);

        // Re-enable: the first sample after 0->1 reports zero deltas.
        c0 = 32'd520; c1 = 32'(-50);
        bus_write(4'd0, 32'd3);
        bus_read(4'd0, d); check("ctrl_irq_en", d, IRQ ? 32'd3 : 32'd1);
        wait_strobe(n);
`ifdef QUAD_SCHED_IRQ_EN
        check("irq_in_publish", 32'(irq), 32'd0);
`endif
        @(negedge clk);
`ifdef QUAD_SCHED_IRQ_EN
        check("irq_rise", 32'(irq), 32'd1);
`endif
        bus_read(4'd8, d); check("s10_delta0", d, 32'd0);
        bus_read(4'd9, d); check("s10_delta1", d, 32'd0);
        bus_read(4'd4, d); check("s10_pos0",   d, 32'd20);
        bus_read(4'd5, d); check("s10_pos1",   d, 32'(-50));
        bus_read(4'd2, d); check("s10_seq",    d, 32'd10);
        bus_read(4'd3, d); check("s10_status", d, IRQ ? 32'd4 : 32'd0);
        bus_write(4'd3, 32'd4);
`ifdef QUAD_SCHED_IRQ_EN
        check("irq_clear", 32'(irq), 32'd0);
`endif

        // Reset in the middle of DIFF.
        wait_strobe(n);
        bus_read(4'd2, d); check("s11_seq", d, 32'd11);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_readdata",    readdata, 32'd0);
        check("midrst_waitrequest", 32'(waitrequest), 32'd0);
        check("midrst_strobe",      32'(sample_strobe), 32'd0);
`ifdef QUAD_SCHED_IRQ_EN
        check("midrst_irq",         32'(irq), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        bus_read(4'd2, d); check("midrst_seq",    d, 32'd0);
        bus_read(4'd0, d); check("midrst_ctrl",   d, 32'd0);
        bus_read(4'd1, d); check("midrst_period", d, 32'd50000);
        bus_read(4'd3, d); check("midrst_status", d, 32'd0);
        bus_read(4'd4, d); check("midrst_pos0",   d, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/quad_sample_scheduler.md
# quad_sample_scheduler

Periodic sampling controller for the quadrature encoder counters in the myo-muscle position path. It owns a programmable sample timer and latches all NUM_ENC raw encoder counts in the same clock cycle. It then walks the channels one per cycle through a shared subtractor to produce offset-corrected positions and per-period deltas. Results are published atomically to an Avalon-MM slave register bank read by the HPS.

## Interface
- NUM_ENC, 2, number of encoder channels (1..4)
- DEFAULT_PERIOD, 50000, sample period in clk cycles after reset (1 kHz at 50 MHz)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- address  in  4  Avalon word address
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- read  in  1  Avalon read strobe
- readdata  out  32  Avalon read data; reset 0
- waitrequest  out  1  Avalon wait; reset 0
- counts  in  32*NUM_ENC  raw signed encoder counts; channel i at bits [32i+31:32i]
- sample_strobe  out  1  one-cycle pulse on each publish; reset 0
- irq  out  1  only with QUAD_SCHED_IRQ_EN; reset 0

## Operation
- Register map:
  - 0 CTRL (rw): bit0 enable, bit1 irq_en
  - 1 PERIOD (rw)
  - 2 SEQ (ro): publish count
  - 3 STATUS: bit0 busy (ro), bit1 overrun (sticky, write-1-clear), bit2 irq pending (w1c)
  - 4+i POS_i (ro): position; a write of any value sets offset_i <= raw count_i
  - 8+i DELTA_i (ro): delta
  - any other address reads 32'hDEADBEEF
- Reset values: CTRL 0, PERIOD DEFAULT_PERIOD, SEQ 0, STATUS 0, offsets 0, POS 0, DELTA 0, FSM IDLE, first-sample flag set.
- Timer:
  - Down-counter reloads PERIOD-1. While enable=1 it decrements; on reaching 0 it emits a tick and reloads.
  - While enable=0 it is held at the reload value.
  - A PERIOD write clamps values <16 to 16 and restarts the timer.
- FSM states: IDLE -> LATCH -> DIFF -> PUBLISH -> IDLE.
  - IDLE: leaves on tick.
  - LATCH: all raw counts copied to the snapshot in one cycle.
  - DIFF: index k = 0..NUM_ENC-1, one channel per cycle. pos_k = raw_k - offset_k. delta_k = raw_k - prev_raw_k. Both are 32-bit modular (wrap-around, no saturation). prev_raw_k <= raw_k.
  - PUBLISH: shadow copied to POS/DELTA in one cycle; SEQ++ (wraps at 2^32); sample_strobe=1; irq pending set; first-sample flag cleared.
- First sample after reset or after an enable 0->1 transition: every DELTA is 0.
- A tick arriving while the FSM is not in IDLE is dropped and sets overrun.
- Clearing enable mid-sequence: the sequence completes and publishes.
- Offset write in the same cycle as LATCH: LATCH uses the old offset; the new offset applies from the next sample. Deltas use raw counts, so an offset change never creates a delta spike.
- Reset mid-sequence aborts the sequence immediately; all state returns to reset values.

## Timing
- Tick at cycle T:
  - LATCH at T+1
  - DIFF at T+2 .. T+1+NUM_ENC
  - PUBLISH at T+2+NUM_ENC
  - sample_strobe high for exactly that PUBLISH cycle
  - published values visible to reads issued from T+3+NUM_ENC
- Busy = FSM not in IDLE.
- Read handshake:
  - Cycle of read assertion: waitrequest=1 and data is registered.
  - Next cycle: waitrequest=0 and readdata is valid.
  - readdata holds its value until the next read.
  - Reads of register 2 or 3 in the same cycle as PUBLISH return pre-publish values.
- Writes: zero wait states, taking effect on the clock edge with write=1. A write is ignored if waitrequest=1.
- Software coherency: read SEQ, then the data registers, then SEQ again; retry if the two SEQ values differ.

## Configuration
- QUAD_SCHED_IRQ_EN defined:
  - irq port present, irq = pending & irq_en (registered, one cycle after PUBLISH).
  - Pending is cleared by writing STATUS bit2 = 1; a clear coinciding with PUBLISH leaves pending set.
- Undefined: no irq port; CTRL bit1 and STATUS bit2 are write-ignored and read 0.

## Test plan
- Reset with counts = {100, -5}; enable with PERIOD=16 -> first publish: POS = {100, -5}, DELTA = {0, 0}, SEQ = 1; sample_strobe asserted 20 cycles after the enable write, one cycle wide (NUM_ENC=2).
- Counts ramp +3 per sample on ch0 and -7 on ch1 -> DELTA = {3, -7} on every subsequent publish.
- ch0 count steps 32'h7FFFFFFF -> 32'h80000002 between samples -> DELTA_0 = 3 (modular wrap).
- Write address 4 while count_0 = 500; next sample with count_0 = 510 -> POS_0 = 10, DELTA_0 unaffected by the offset write.
- Write PERIOD = 3 -> PERIOD reads 16. Force a tick during DIFF via a timer override in the bench -> STATUS.overrun = 1, SEQ not incremented twice. Write STATUS = 2 -> overrun reads 0.
- With QUAD_SCHED_IRQ_EN and irq_en = 1 -> irq rises one cycle after PUBLISH; write STATUS = 4 -> irq = 0. Assert reset mid-DIFF -> all outputs 0 and SEQ = 0.
